pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline register: the generalised successor of the fixed five-field decode/execute latch. It carries NUM_CH channels of DATA_W bits through DEPTH chained stages, with a valid bit per stage. It supports stall (hold), flush (bubble insertion) and NOP-on-invalid loading. Saturating stall/flush event counters feed the hazard unit and debug. It drops in between any two CPU pipeline stages (D/E, E/M, M/W).

Parameters:
DATA_W, 32, width of one channel (instr, RD1, RD2, ext, PC4 ...)
NUM_CH, 5, number of channels carried
DEPTH, 1, number of chained register stages (latency); legal 1..4
CNT_W, 16, width of each event counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
d_in  in  NUM_CH*DATA_W  packed channels, channel k at bits [k*DATA_W +: DATA_W]
valid_in  in  1  d_in holds a real instruction
stall  in  1  hold every stage this cycle
flush  in  1  replace every stage with a bubble this cycle
cnt_clr  in  1  synchronous clear of both counters
d_out  out  NUM_CH*DATA_W  last-stage contents
valid_out  out  1  last-stage valid
stall_cnt  out  CNT_W  cycles with stall=1 and flush=0, saturating
flush_cnt  out  CNT_W  cycles with flush=1, saturating

Behaviour:
- Reset is asynchronous and active-high. While it is asserted, all stage data=0, all valid=0, both counters=0, so d_out=0 and valid_out=0 immediately. After deassertion, operation resumes on the next rising clk edge.
- Each rising edge applies exactly one action, in priority order: reset > flush > stall > load.
- flush=1: every stage data <= 0 and valid <= 0. The stall input is ignored that cycle. Flush+stall together therefore yields bubbles, not a hold.
- stall=1, flush=0: every stage keeps its data and valid unchanged. Nothing enters and nothing advances.
- Load (stall=0, flush=0):
  - stage0 <= d_in and valid0 <= 1 if valid_in=1; otherwise stage0 <= 0 (the all-zero encoding is a NOP) and valid0 <= 0.
  - stage i <= stage i-1 for i=1..DEPTH-1, data and valid moving together.
- Latency: an item loaded at edge n appears on d_out/valid_out after edge n+DEPTH-1 (DEPTH=1: visible right after its capture edge), plus one extra cycle per stalled edge.
- Data and valid of one stage always move together. No stage may hold data≠0 with valid=0.
- d_out and valid_out are driven straight from the last stage's registers, with no combinational path from the inputs.
- Counters:
  - stall_cnt increments on edges with stall=1 and flush=0.
  - flush_cnt increments on edges with flush=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - cnt_clr=1 sets both to 0 on that edge and takes priority over increment. It does not affect the pipeline data.
- Reset asserted mid-stall or mid-flush: all state clears at once. Pending events are not counted.
- No initial blocks. Register state comes only from reset.

Test Plan:
1. Reset then load, DEPTH=1, NUM_CH=5: d_in={PC4=0x3004, ext=0x10, RD2=7, RD1=5, instr=0x8C220010}, valid_in=1, one edge -> d_out equals d_in, valid_out=1. Assert reset between edges -> d_out=0 and valid_out=0 with no clock edge.
2. Stall hold: load item A, then stall=1 for 3 edges while d_in=B -> d_out stays A, valid_out=1, stall_cnt=3. Release -> B on the next edge.
3. Flush priority: flush=1 and stall=1 on the same edge with A held -> d_out=0, valid_out=0, flush_cnt=1, stall_cnt unchanged.
4. DEPTH=3 latency: feed A,B,C on consecutive edges with valid_in=1, then valid_in=0 -> A visible after edge 3, B after 4, C after 5, then d_out=0 with valid_out=0. A stall at edge 2 delays every item by one edge.
5. Counter saturation and clear, CNT_W=4: 20 stall edges -> stall_cnt=15. cnt_clr with stall=1 on the same edge -> stall_cnt=0.
6. Invalid load: valid_in=0 with d_in=0xFFFF... -> d_out=0, valid_out=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register: NUM_CH channels through DEPTH stages,
// with stall/flush control and saturating stall/flush event counters.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 5,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] d_in,
    input  logic                     valid_in,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     cnt_clr,
    output logic [NUM_CH*DATA_W-1:0] d_out,
    output logic                     valid_out,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    localparam int W = NUM_CH * DATA_W;

    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH must be 1..4");
    end

    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = '0;
            end
            vld_d = '0;
        end else if (!stall) begin
            // Invalid loads enter as all-zero NOPs so data never outlives valid.
            data_d[0] = valid_in ? d_in : '0;
            vld_d[0]  = valid_in;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && !flush && stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush && flush_cnt_q != '1) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            vld_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            data_q      <= data_d;
            vld_q       <= vld_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign d_out     = data_q[DEPTH-1];
    assign valid_out = vld_q[DEPTH-1];
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: three instances (DEPTH=1, DEPTH=3,
// CNT_W=4) driven by directed vectors with hand-computed expectations.
module tb_pipe_stage_reg;

    localparam int W = 160;

    typedef struct {
        int          sel;
        bit          as;
        logic        rst;
        logic [W-1:0] d;
        logic        vi;
        logic        st;
        logic        fl;
        logic        cl;
        logic [W-1:0] ed;
        logic        ev;
        logic [15:0] es;
        logic [15:0] ef;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a [3];
    logic [W-1:0] din_a [3];
    logic         vin_a [3];
    logic         stl_a [3];
    logic         fls_a [3];
    logic         clr_a [3];

    logic [W-1:0] dout_a [3];
    logic         vout_a [3];
    logic [15:0]  sc0, sc1, fc0, fc1;
    logic [3:0]   sc2, fc2;

    pipe_stage_reg #(.DATA_W(32), .NUM_CH(5), .DEPTH(1), .CNT_W(16)) u_d1 (
        .clk(clk), .reset(rst_a[0]), .d_in(din_a[0]), .valid_in(vin_a[0]),
        .stall(stl_a[0]), .flush(fls_a[0]), .cnt_clr(clr_a[0]),
        .d_out(dout_a[0]), .valid_out(vout_a[0]),
        .stall_cnt(sc0), .flush_cnt(fc0));

    pipe_stage_reg #(.DATA_W(32), .NUM_CH(5), .DEPTH(3), .CNT_W(16)) u_d3 (
        .clk(clk), .reset(rst_a[1]), .d_in(din_a[1]), .valid_in(vin_a[1]),
        .stall(stl_a[1]), .flush(fls_a[1]), .cnt_clr(clr_a[1]),
        .d_out(dout_a[1]), .valid_out(vout_a[1]),
        .stall_cnt(sc1), .flush_cnt(fc1));

    pipe_stage_reg #(.DATA_W(32), .NUM_CH(5), .DEPTH(1), .CNT_W(4)) u_c4 (
        .clk(clk), .reset(rst_a[2]), .d_in(din_a[2]), .valid_in(vin_a[2]),
        .stall(stl_a[2]), .flush(fls_a[2]), .cnt_clr(clr_a[2]),
        .d_out(dout_a[2]), .valid_out(vout_a[2]),
        .stall_cnt(sc2), .flush_cnt(fc2));

    vec_t vecs[$];
    vec_t sb[$];
    event chk;
    int   n_vec = 0;
    int   n_err = 0;
    bit   done  = 1'b0;

    localparam logic [W-1:0] T1 = {32'h3004, 32'h10, 32'd7, 32'd5, 32'h8C220010};
    localparam logic [W-1:0] VA = {32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [W-1:0] VB = {32'hB4, 32'hB3, 32'hB2, 32'hB1, 32'hB0};
    localparam logic [W-1:0] VC = {32'hC4, 32'hC3, 32'hC2, 32'hC1, 32'hC0};
    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] Z = '0;

    function automatic void add(int sel, bit as, logic r, logic [W-1:0] d,
                                logic vi, logic st, logic fl, logic cl,
                                logic [W-1:0] ed, logic ev, int es, int ef);
        vec_t v;
        v.sel = sel; v.as = as; v.rst = r; v.d = d; v.vi = vi;
        v.st = st; v.fl = fl; v.cl = cl; v.ed = ed; v.ev = ev;
        v.es = 16'(es); v.ef = 16'(ef);
        vecs.push_back(v);
    endfunction

    function automatic int sat15(int n);
        return (n > 15) ? 15 : n;
    endfunction

    task automatic build();
        // DEPTH=1: load, async reset, stall hold, flush priority, invalid load
        add(0, 0, 1, Z,    0, 0, 0, 0, Z,  0, 0, 0);
        add(0, 0, 0, T1,   1, 0, 0, 0, T1, 1, 0, 0);
        add(0, 1, 1, T1,   1, 0, 0, 0, Z,  0, 0, 0);
        add(0, 0, 0, VA,   1, 0, 0, 0, VA, 1, 0, 0);
        add(0, 0, 0, VB,   1, 1, 0, 0, VA, 1, 1, 0);
        add(0, 0, 0, VB,   1, 1, 0, 0, VA, 1, 2, 0);
        add(0, 0, 0, VB,   1, 1, 0, 0, VA, 1, 3, 0);
        add(0, 0, 0, VB,   1, 0, 0, 0, VB, 1, 3, 0);
        add(0, 0, 0, VC,   1, 1, 1, 0, Z,  0, 3, 1);
        add(0, 0, 0, VA,   1, 0, 0, 0, VA, 1, 3, 1);
        add(0, 0, 0, ONES, 0, 0, 0, 0, Z,  0, 3, 1);
        add(0, 0, 0, VC,   1, 0, 0, 0, VC, 1, 3, 1);
        add(0, 0, 0, VC,   1, 1, 0, 0, VC, 1, 4, 1);
        add(0, 1, 1, VC,   1, 1, 0, 0, Z,  0, 0, 0);
        add(0, 0, 1, VC,   1, 1, 1, 0, Z,  0, 0, 0);
        add(0, 0, 0, Z,    0, 1, 0, 0, Z,  0, 1, 0);
        add(0, 0, 0, Z,    0, 0, 1, 1, Z,  0, 0, 0);
        // DEPTH=3: plain latency, then the same with a stall at edge 2
        add(1, 0, 1, Z,    0, 0, 0, 0, Z,  0, 0, 0);
        add(1, 0, 0, VA,   1, 0, 0, 0, Z,  0, 0, 0);
        add(1, 0, 0, VB,   1, 0, 0, 0, Z,  0, 0, 0);
        add(1, 0, 0, VC,   1, 0, 0, 0, VA, 1, 0, 0);
        add(1, 0, 0, ONES, 0, 0, 0, 0, VB, 1, 0, 0);
        add(1, 0, 0, ONES, 0, 0, 0, 0, VC, 1, 0, 0);
        add(1, 0, 0, ONES, 0, 0, 0, 0, Z,  0, 0, 0);
        add(1, 0, 0, VA,   1, 0, 0, 0, Z,  0, 0, 0);
        add(1, 0, 0, VB,   1, 1, 0, 0, Z,  0, 1, 0);
        add(1, 0, 0, VB,   1, 0, 0, 0, Z,  0, 1, 0);
        add(1, 0, 0, VC,   1, 0, 0, 0, VA, 1, 1, 0);
        add(1, 0, 0, Z,    0, 0, 0, 0, VB, 1, 1, 0);
        add(1, 0, 0, Z,    0, 0, 0, 0, VC, 1, 1, 0);
        add(1, 0, 0, Z,    0, 0, 0, 0, Z,  0, 1, 0);
        // DEPTH=3 flush wipes every stage, not just the last
        add(1, 0, 0, VA,   1, 0, 0, 0, Z,  0, 1, 0);
        add(1, 0, 0, VB,   1, 0, 0, 0, Z,  0, 1, 0);
        add(1, 0, 0, VC,   1, 0, 1, 0, Z,  0, 1, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 0, Z, 0, 0, 0, 0, Z, 0, 1, 1);
        // CNT_W=4: saturation and clear priority
        add(2, 0, 1, Z, 0, 0, 0, 0, Z, 0, 0, 0);
        for (int i = 1; i <= 20; i++) add(2, 0, 0, Z, 0, 1, 0, 0, Z, 0, sat15(i), 0);
        add(2, 0, 0, Z, 0, 1, 0, 1, Z, 0, 0, 0);
        add(2, 0, 0, Z, 0, 1, 0, 0, Z, 0, 1, 0);
        for (int i = 1; i <= 17; i++) add(2, 0, 0, Z, 0, 0, 1, 0, Z, 0, 1, sat15(i));
        add(2, 0, 0, Z, 0, 0, 0, 1, Z, 0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_a[k] = 1'b1; din_a[k] = '0; vin_a[k] = 1'b0;
            stl_a[k] = 1'b0; fls_a[k] = 1'b0; clr_a[k] = 1'b0;
        end
        build();
        repeat (2) @(negedge clk);
        foreach (vecs[n]) begin
            vec_t v;
            v = vecs[n];
            @(negedge clk);
            rst_a[v.sel] = v.rst; din_a[v.sel] = v.d; vin_a[v.sel] = v.vi;
            stl_a[v.sel] = v.st; fls_a[v.sel] = v.fl; clr_a[v.sel] = v.cl;
            sb.push_back(v);
            if (v.as) begin
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
            -> chk;
        end
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        done = 1'b1;
        $finish;
    end

    initial begin
        forever begin
            vec_t e;
            logic [W-1:0] gd;
            logic gv;
            logic [15:0] gs, gf;
            @(chk);
            e = sb.pop_front();
            gd = dout_a[e.sel];
            gv = vout_a[e.sel];
            case (e.sel)
                0: begin gs = sc0; gf = fc0; end
                1: begin gs = sc1; gf = fc1; end
                default: begin gs = {12'd0, sc2}; gf = {12'd0, fc2}; end
            endcase
            n_vec++;
            if (gd !== e.ed) begin
                n_err++;
                $display("FAIL v%0d dut%0d d_out: got %h want %h", n_vec, e.sel, gd, e.ed);
            end
            if (gv !== e.ev) begin
                n_err++;
                $display("FAIL v%0d dut%0d valid_out: got %b want %b", n_vec, e.sel, gv, e.ev);
            end
            if (gs !== e.es) begin
                n_err++;
                $display("FAIL v%0d dut%0d stall_cnt: got %0d want %0d", n_vec, e.sel, gs, e.es);
            end
            if (gf !== e.ef) begin
                n_err++;
                $display("FAIL v%0d dut%0d flush_cnt: got %0d want %0d", n_vec, e.sel, gf, e.ef);
            end
        end
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: got no finish want finish");
            $fatal(1, "timeout");
        end
    end

endmodule
